// File: rtl/pwm_preconditioner.sv
// pwm_preconditioner
//   Turns the silencer's per-transducer (intensity, phase) stream into PWM edge
//   ticks. Intensity addresses an external pulse-width table; the returned width
//   is clamped to half a period and centred on the phase to produce RISE/FALL
//   ticks inside the 512-tick ultrasound period.
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   DIN_VALID         input element valid
//   INTENSITY_IN      16-bit intensity, used directly as table address
//   PHASE_IN          8-bit phase, 256 steps per period
//   TABLE_ADDR        registered table read address (holds when idle)
//   TABLE_DATA        table pulse width, valid TABLE_LAT cycles after address
//   RISE, FALL        9-bit edge ticks, mod 512
//   IDX               transducer index of the output element
//   DOUT_VALID        RISE/FALL/IDX valid
//   DOUT_LAST         last element of a frame (IDX == DEPTH-1)
//   FRAME_ERR         sticky flag: a frame shorter than DEPTH was seen
module pwm_preconditioner #(
    parameter int DEPTH     = 249,
    parameter int TABLE_LAT = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DIN_VALID,
    input  logic [15:0] INTENSITY_IN,
    input  logic [7:0]  PHASE_IN,
    output logic [15:0] TABLE_ADDR,
    input  logic [8:0]  TABLE_DATA,
    output logic [8:0]  RISE,
    output logic [8:0]  FALL,
    output logic [7:0]  IDX,
    output logic        DOUT_VALID,
    output logic        DOUT_LAST,
    output logic        FRAME_ERR
);

    localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);
    localparam logic [8:0] PW_MAX   = 9'd256;

    // Input frame counter
    logic [7:0] cnt;

    // Delay line aligning phase/idx/last with the table read; stage 0 is
    // loaded on the same edge that registers TABLE_ADDR.
    logic [TABLE_LAT-1:0] vld_pipe;
    logic [7:0]           ph_pipe   [TABLE_LAT];
    logic [7:0]           idx_pipe  [TABLE_LAT];
    logic [TABLE_LAT-1:0] last_pipe;

    // Capture stage: table data joins the element here, already clamped
    logic       cap_vld;
    logic [8:0] cap_pw;
    logic [7:0] cap_ph;
    logic [7:0] cap_idx;
    logic       cap_last;

    // Edge arithmetic: floor half goes before the centre, ceil half after,
    // so FALL - RISE always equals the pulse width exactly.
    logic [8:0] centre;
    logic [8:0] half_lo;
    logic [8:0] half_hi;

    always_comb begin
        centre  = {cap_ph, 1'b0};
        half_lo = {1'b0, cap_pw[8:1]};
        half_hi = cap_pw - half_lo;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt        <= '0;
            FRAME_ERR  <= 1'b0;
            TABLE_ADDR <= '0;
        end else if (DIN_VALID) begin
            TABLE_ADDR <= INTENSITY_IN;
            cnt        <= (cnt == LAST_IDX) ? 8'd0 : cnt + 8'd1;
        end else if (cnt != 8'd0) begin
            // Short frame: flag it and resync so the next element is IDX 0
            FRAME_ERR <= 1'b1;
            cnt       <= '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            for (int i = 0; i < TABLE_LAT; i++) begin
                ph_pipe[i]  <= '0;
                idx_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0]  <= DIN_VALID;
            last_pipe[0] <= DIN_VALID && (cnt == LAST_IDX);
            ph_pipe[0]   <= PHASE_IN;
            idx_pipe[0]  <= cnt;
            for (int i = 1; i < TABLE_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
                ph_pipe[i]   <= ph_pipe[i-1];
                idx_pipe[i]  <= idx_pipe[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cap_vld  <= 1'b0;
            cap_pw   <= '0;
            cap_ph   <= '0;
            cap_idx  <= '0;
            cap_last <= 1'b0;
        end else begin
            cap_vld  <= vld_pipe[TABLE_LAT-1];
            cap_last <= last_pipe[TABLE_LAT-1];
            cap_pw   <= (TABLE_DATA > PW_MAX) ? PW_MAX : TABLE_DATA;
            cap_ph   <= ph_pipe[TABLE_LAT-1];
            cap_idx  <= idx_pipe[TABLE_LAT-1];
        end
    end

    // Output register: data holds across gaps, only the flags drop
    always_ff @(posedge CLK) begin
        if (RST) begin
            RISE       <= '0;
            FALL       <= '0;
            IDX        <= '0;
            DOUT_VALID <= 1'b0;
            DOUT_LAST  <= 1'b0;
        end else begin
            DOUT_VALID <= cap_vld;
            DOUT_LAST  <= cap_vld && cap_last;
            if (cap_vld) begin
                RISE <= centre - half_lo;
                FALL <= centre + half_hi;
                IDX  <= cap_idx;
            end
        end
    end

endmodule

// File: tb/tb_pwm_preconditioner.sv
module tb_pwm_preconditioner;

    localparam int DEPTH = 249;
    localparam int LAT   = 3;   // input edge to output edge

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        DIN_VALID = 1'b0;
    logic [15:0] INTENSITY_IN = '0;
    logic [7:0]  PHASE_IN = '0;
    logic [15:0] TABLE_ADDR;
    logic [8:0]  TABLE_DATA = '0;
    logic [8:0]  RISE, FALL;
    logic [7:0]  IDX;
    logic        DOUT_VALID, DOUT_LAST, FRAME_ERR;

    pwm_preconditioner #(.DEPTH(DEPTH), .TABLE_LAT(2)) dut (
        .CLK(CLK), .RST(RST), .DIN_VALID(DIN_VALID),
        .INTENSITY_IN(INTENSITY_IN), .PHASE_IN(PHASE_IN),
        .TABLE_ADDR(TABLE_ADDR), .TABLE_DATA(TABLE_DATA),
        .RISE(RISE), .FALL(FALL), .IDX(IDX),
        .DOUT_VALID(DOUT_VALID), .DOUT_LAST(DOUT_LAST), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    // Table: width = address mod 512, data ready on the second edge after
    // the address is launched (one edge for TABLE_ADDR, one inside the BRAM).
    always @(posedge CLK) TABLE_DATA <= TABLE_ADDR[8:0];

    int n_cmp = 0;
    int n_err = 0;

    // Expected output per input edge, ring of LAT+1 slots
    bit hv   [LAT+1];
    int hr   [LAT+1];
    int hf   [LAT+1];
    int hidx [LAT+1];
    bit hlast[LAT+1];

    int edge_n   = 0;
    int pos      = 0;
    bit exp_ferr = 0;
    int exp_addr = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model, then check outputs 1ns after the edge
    task automatic step(input bit v, input int inten, input int ph, input bit rst = 0);
        int s, o, pw, c;
        RST = rst; DIN_VALID = v;
        INTENSITY_IN = 16'(inten); PHASE_IN = 8'(ph);
        @(posedge CLK);
        s = edge_n % (LAT + 1);
        o = (edge_n + 1) % (LAT + 1);
        if (rst) begin
            for (int i = 0; i <= LAT; i++) hv[i] = 0;
            pos = 0; exp_ferr = 0; exp_addr = 0;
        end else begin
            hv[s] = v;
            if (v) begin
                pw = inten % 512;
                if (pw > 256) pw = 256;
                c = ph * 2;
                hr[s]    = (c - pw / 2 + 512) % 512;
                hf[s]    = (c + (pw + 1) / 2) % 512;
                hidx[s]  = pos;
                hlast[s] = (pos == DEPTH - 1);
                pos      = (pos + 1) % DEPTH;
                exp_addr = inten % 65536;
            end else if (pos != 0) begin
                exp_ferr = 1;
                pos = 0;
            end
        end
        edge_n++;
        #1;
        if (!rst) begin
            chk("dout_valid", int'(DOUT_VALID), int'(hv[o]));
            chk("dout_last", int'(DOUT_LAST), int'(hv[o] && hlast[o]));
            if (hv[o] && DOUT_VALID) begin
                chk("rise", int'(RISE), hr[o]);
                chk("fall", int'(FALL), hf[o]);
                chk("idx", int'(IDX), hidx[o]);
            end
            chk("frame_err", int'(FRAME_ERR), int'(exp_ferr));
            chk("table_addr", int'(TABLE_ADDR), exp_addr);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic rnd(input int n);
        for (int i = 0; i < n; i++)
            step(1, int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, int'(DOUT_VALID), 0);
        chk({tag, "_last"}, int'(DOUT_LAST), 0);
        chk({tag, "_rise"}, int'(RISE), 0);
        chk({tag, "_fall"}, int'(FALL), 0);
        chk({tag, "_idx"}, int'(IDX), 0);
        chk({tag, "_ferr"}, int'(FRAME_ERR), 0);
        chk({tag, "_addr"}, int'(TABLE_ADDR), 0);
    endtask

    initial begin
        for (int i = 0; i <= LAT; i++) hv[i] = 0;

        // Reset
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk_reset_state("reset");
        idle(2);

        // Directed edge cases: pw=0, wrap below 0, wrap above 511
        step(1, 0, 10);
        step(1, 256, 0);
        step(1, 101, 255);
        step(0, 0, 0);
        chk("t1_rise", int'(RISE), 20);
        chk("t1_fall", int'(FALL), 20);
        step(0, 0, 0);
        chk("t2_rise", int'(RISE), 384);
        chk("t2_fall", int'(FALL), 128);
        step(0, 0, 0);
        chk("t3_rise", int'(RISE), 460);
        chk("t3_fall", int'(FALL), 49);
        idle(2);

        // Clean frame after reset
        step(0, 0, 0, 1);
        idle(2);
        rnd(DEPTH);
        idle(5);
        chk("t4_ferr", int'(FRAME_ERR), 0);

        // Short frame, then a frame held past DEPTH (wrap, no new error)
        rnd(100);
        idle(5);
        chk("t5_ferr", int'(FRAME_ERR), 1);
        rnd(DEPTH + 10);
        idle(5);

        // Clamp above 256, reset mid-frame
        step(0, 0, 0, 1);
        idle(2);
        for (int i = 0; i < 50; i++) step(1, 300 + (i % 3) * 100, i * 5);
        step(1, 300, 7, 1);
        chk_reset_state("t6");
        idle(5);
        for (int i = 0; i < 4; i++) step(1, 300, 128);
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
